// File: rtl/timer_scheduler_if.sv
// Request/grant bundle between slow-event consumers and the shared timer scheduler.
// The requesters drive req/delay; the scheduler drives grant/done/busy/cur_id.
interface timer_scheduler_if #(
  parameter int NREQ = 4,
  parameter int CW   = 32
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]    req;
  logic [NREQ*CW-1:0] delay;
  logic [NREQ-1:0]    grant;
  logic [NREQ-1:0]    done;
  logic               busy;
  logic [IW-1:0]      cur_id;

  modport master (
    output req,
    output delay,
    input  grant,
    input  done,
    input  busy,
    input  cur_id
  );

  modport slave (
    input  req,
    input  delay,
    output grant,
    output done,
    output busy,
    output cur_id
  );
endinterface

// File: rtl/timer_scheduler.sv
// Shared prescaled down-counter timer. A round-robin arbiter hands the single countdown
// to one requester at a time; when its delay (in ticks of PRESCALE clk cycles) expires
// the owner gets a one-cycle done pulse. Dropping req while owning the timer aborts it.
module timer_scheduler #(
  parameter int NREQ     = 4,
  parameter int CW       = 32,
  parameter int PRESCALE = 50000000
) (
  input  logic             clk,
  input  logic             rst,
  timer_scheduler_if.slave bus
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  // A prescaler of PRESCALE=1 still needs one (constant zero) bit.
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);
  localparam logic [IW-1:0] ID_LAST = IW'(NREQ - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [IW-1:0] ptr;
  logic [CW-1:0] remaining;
  logic [PW-1:0] prescaler;

  logic          found;
  logic [IW-1:0] winner;
  logic [IW-1:0] cand;
  logic [CW-1:0] win_delay;
  logic          tick;
  logic          owner_req;

  function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] id);
    logic [NREQ-1:0] v;
    v     = '0;
    v[id] = 1'b1;
    return v;
  endfunction

  assign tick      = (prescaler == PS_LAST);
  assign owner_req = bus.req[bus.cur_id];

  // Round-robin search: first set req bit starting just after the last owner, wrapping.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand   = IW'((int'(ptr) + k) % NREQ);
      winner = (!found && bus.req[cand]) ? cand : winner;
      found  = found | bus.req[cand];
    end
  end

  // Select the delay belonging to the arbitration winner so it can be latched at grant.
  always_comb begin
    win_delay = '0;
    for (int i = 0; i < NREQ; i++) begin
      win_delay = (IW'(i) == winner) ? bus.delay[i*CW +: CW] : win_delay;
    end
  end

  // Scheduler FSM: arbitration, prescaled countdown, abort and done pulse, all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= ID_LAST;
      remaining  <= '0;
      prescaler  <= '0;
      bus.grant  <= '0;
      bus.done   <= '0;
      bus.busy   <= 1'b0;
      bus.cur_id <= '0;
    end else begin
      case (state)
        IDLE: begin
          bus.done  <= '0;
          prescaler <= '0;
          if (found) begin
            state      <= RUN;
            bus.grant  <= onehot(winner);
            bus.busy   <= 1'b1;
            bus.cur_id <= winner;
            ptr        <= winner;
            remaining  <= win_delay;
          end else begin
            state     <= IDLE;
            bus.grant <= '0;
            bus.busy  <= 1'b0;
          end
        end

        RUN: begin
          if (!owner_req) begin
            // Abort wins over expiry; ptr keeps the aborted id so rotation still advances.
            state     <= IDLE;
            bus.grant <= '0;
            bus.done  <= '0;
            bus.busy  <= 1'b0;
            prescaler <= '0;
          end else if (remaining == '0) begin
            // Zero delay: expire immediately without waiting for a tick.
            state     <= DONE;
            bus.grant <= '0;
            bus.done  <= onehot(bus.cur_id);
            bus.busy  <= 1'b1;
            prescaler <= '0;
          end else if (tick) begin
            remaining <= remaining - CW'(1);
            prescaler <= '0;
            if (remaining == CW'(1)) begin
              state     <= DONE;
              bus.grant <= '0;
              bus.done  <= onehot(bus.cur_id);
              bus.busy  <= 1'b1;
            end else begin
              state <= RUN;
            end
          end else begin
            prescaler <= prescaler + PW'(1);
          end
        end

        DONE: begin
          state     <= IDLE;
          bus.grant <= '0;
          bus.done  <= '0;
          bus.busy  <= 1'b0;
          prescaler <= '0;
        end

        default: begin
          state     <= IDLE;
          bus.grant <= '0;
          bus.done  <= '0;
          bus.busy  <= 1'b0;
          prescaler <= '0;
        end
      endcase
    end
  end

endmodule
